// File: rtl/bus_thread_arbiter.sv
// bus_thread_arbiter: four-thread round-robin arbiter in front of a single
// strobe/acknowledge bus. The winning thread's address, data and write flag
// are latched at grant and held until the bus acknowledges.
// Optional feature: define ARB_TIMEOUT_EN to abort a transfer (DONE + ERR)
// after TIMEOUT bus-wait cycles without W_ACK.
//
// state | meaning
// IDLE  | no transfer; grant on any pending request
// BUS   | strobe active, waiting for W_ACK (or timeout)
// FIN   | completion cycle; GNT/DONE cleared on exit
module bus_thread_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         W_CLK,
  input  logic         W_RST,
  input  logic [3:0]   REQ,
  input  logic [3:0]   REQ_WE,
  input  logic [127:0] REQ_ADDR,
  input  logic [127:0] REQ_DAT,
  output logic [3:0]   GNT,
  output logic [3:0]   DONE,
  output logic [3:0]   ERR,
  output logic [31:0]  RD_DAT,
  output logic [1:0]   THREAD,
  output logic [31:0]  W_ADDR,
  output logic [31:0]  W_DAT_O,
  output logic         W_WRITE,
  output logic         W_STB,
  input  logic [31:0]  W_DAT_I,
  input  logic         W_ACK
);

  typedef enum logic [1:0] {IDLE, BUS, FIN} state_t;

  state_t     state;
  logic [1:0] last_winner;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;

  if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("bus_thread_arbiter: TIMEOUT must be 1..65535");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;
`else
  assign ERR = 4'b0000;
`endif

  // Round-robin pick: first requester at or after last_winner+1, wrapping.
  always_comb begin
    pick  = last_winner + 2'd1;
    cand  = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_winner + 2'(i);
      if (!found && REQ[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Arbitration FSM with registered grant, bus and completion outputs.
  always_ff @(posedge W_CLK) begin
    if (W_RST) begin
      state       <= IDLE;
      last_winner <= 2'd3;
      GNT         <= 4'b0000;
      DONE        <= 4'b0000;
      RD_DAT      <= 32'h0;
      THREAD      <= 2'd0;
      W_ADDR      <= 32'h0;
      W_DAT_O     <= 32'h0;
      W_WRITE     <= 1'b0;
      W_STB       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      ERR         <= 4'b0000;
      to_cnt      <= 16'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|REQ) begin
            state       <= BUS;
            last_winner <= pick;
            THREAD      <= pick;
            GNT         <= 4'b0001 << pick;
            W_ADDR      <= REQ_ADDR[{pick, 5'd0} +: 32];
            W_DAT_O     <= REQ_DAT[{pick, 5'd0} +: 32];
            W_WRITE     <= REQ_WE[pick];
            W_STB       <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            to_cnt      <= 16'h0;
`endif
          end
        end
        BUS: begin
          // Acknowledge beats a timeout landing on the same edge.
          if (W_ACK) begin
            if (!W_WRITE) RD_DAT <= W_DAT_I;
            W_STB <= 1'b0;
            DONE  <= GNT;
            state <= FIN;
          end
`ifdef ARB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            W_STB <= 1'b0;
            DONE  <= GNT;
            ERR   <= GNT;
            state <= FIN;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        FIN: begin
          GNT   <= 4'b0000;
          DONE  <= 4'b0000;
`ifdef ARB_TIMEOUT_EN
          ERR   <= 4'b0000;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_thread_arbiter.sv
// Self-checking bench for bus_thread_arbiter (TIMEOUT = 4). The reference
// model tracks the round-robin pointer and the last captured read data.
module tb_bus_thread_arbiter;

  logic         W_CLK = 1'b0;
  logic         W_RST;
  logic [3:0]   REQ;
  logic [3:0]   REQ_WE;
  logic [127:0] REQ_ADDR;
  logic [127:0] REQ_DAT;
  logic [3:0]   GNT;
  logic [3:0]   DONE;
  logic [3:0]   ERR;
  logic [31:0]  RD_DAT;
  logic [1:0]   THREAD;
  logic [31:0]  W_ADDR;
  logic [31:0]  W_DAT_O;
  logic         W_WRITE;
  logic         W_STB;
  logic [31:0]  W_DAT_I;
  logic         W_ACK;

  int n_pass = 0;
  int n_total = 0;

  // model state
  int          lw;
  logic [31:0] m_rd;

  bus_thread_arbiter #(.TIMEOUT(4)) dut (
    .W_CLK(W_CLK), .W_RST(W_RST), .REQ(REQ), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_DAT(REQ_DAT), .GNT(GNT), .DONE(DONE),
    .ERR(ERR), .RD_DAT(RD_DAT), .THREAD(THREAD), .W_ADDR(W_ADDR),
    .W_DAT_O(W_DAT_O), .W_WRITE(W_WRITE), .W_STB(W_STB),
    .W_DAT_I(W_DAT_I), .W_ACK(W_ACK)
  );

  always #5 W_CLK = ~W_CLK;

  task automatic tick();
    @(posedge W_CLK);
    #1;
  endtask

  function automatic int model_pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(lw + k) % 4]) return (lw + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    W_RST = 1'b1; REQ = 4'h0; REQ_WE = 4'h0; W_ACK = 1'b0;
    REQ_ADDR = '0; REQ_DAT = '0; W_DAT_I = 32'h0;
    tick(); tick();
    W_RST = 1'b0;
    lw = 3; m_rd = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({GNT, DONE, ERR, W_STB, W_WRITE} !== 15'h0) $display("FAIL reset_ctrl: got gnt=%b done=%b err=%b stb=%b wr=%b, want all 0", GNT, DONE, ERR, W_STB, W_WRITE);
    else n_pass++;
    n_total++;
    if ({W_ADDR, W_DAT_O, RD_DAT, THREAD} !== 98'h0) $display("FAIL reset_data: got addr=%h dato=%h rd=%h thr=%0d, want 0", W_ADDR, W_DAT_O, RD_DAT, THREAD);
    else n_pass++;
  endtask

  task automatic test_single_read();
    REQ = 4'b0001; REQ_WE = 4'b0000; REQ_ADDR = rnd128(); REQ_ADDR[31:0] = 32'h100;
    tick();
    lw = 0;
    n_total++;
    if ({W_STB, GNT, W_WRITE, W_ADDR} !== {1'b1, 4'b0001, 1'b0, 32'h100}) $display("FAIL read_grant: got stb=%b gnt=%b wr=%b addr=%h, want 1 0001 0 00000100", W_STB, GNT, W_WRITE, W_ADDR);
    else n_pass++;
    tick(); tick();
    W_ACK = 1'b1; W_DAT_I = 32'hDEADBEEF;
    tick();
    m_rd = 32'hDEADBEEF;
    n_total++;
    if ({DONE, W_STB, RD_DAT} !== {4'b0001, 1'b0, m_rd}) $display("FAIL read_done: got done=%b stb=%b rd=%h, want 0001 0 %h", DONE, W_STB, RD_DAT, m_rd);
    else n_pass++;
    W_ACK = 1'b0; REQ = 4'h0;
    tick();
    n_total++;
    if ({DONE, GNT} !== 8'h0) $display("FAIL read_fin: got done=%b gnt=%b, want 0 0", DONE, GNT);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int cnt;
    int exp_w;
    do_reset();
    REQ = 4'hF; REQ_WE = 4'h0;
    for (int t = 0; t < 5; t++) begin
      cnt = 0;
      while (!W_STB && cnt < 20) begin tick(); cnt++; end
      exp_w = t % 4;
      n_total++;
      if (cnt !== ((t == 0) ? 1 : 2)) $display("FAIL rr_gap%0d: got %0d cycles to strobe, want %0d", t, cnt, (t == 0) ? 1 : 2);
      else n_pass++;
      n_total++;
      if ({THREAD, GNT} !== {2'(exp_w), 4'(4'b0001 << exp_w)}) $display("FAIL rr_order%0d: got thread=%0d gnt=%b, want thread=%0d", t, THREAD, GNT, exp_w);
      else n_pass++;
      W_ACK = 1'b1; W_DAT_I = $urandom();
      m_rd = W_DAT_I;
      tick();
      W_ACK = 1'b0;
      n_total++;
      if ({DONE, RD_DAT} !== {4'(4'b0001 << exp_w), m_rd}) $display("FAIL rr_done%0d: got done=%b rd=%h, want thread %0d rd=%h", t, DONE, RD_DAT, exp_w, m_rd);
      else n_pass++;
    end
    lw = 0;
    REQ = 4'h0;
    tick(); tick();
  endtask

  task automatic test_write();
    REQ = 4'b0100; REQ_WE = 4'b0100; REQ_ADDR = rnd128(); REQ_DAT = rnd128();
    REQ_ADDR[95:64] = 32'h2000; REQ_DAT[95:64] = 32'h12345678;
    tick();
    lw = 2;
    n_total++;
    if ({W_WRITE, W_ADDR, W_DAT_O, THREAD, GNT} !== {1'b1, 32'h2000, 32'h12345678, 2'd2, 4'b0100}) $display("FAIL write_grant: got wr=%b addr=%h dato=%h thr=%0d gnt=%b", W_WRITE, W_ADDR, W_DAT_O, THREAD, GNT);
    else n_pass++;
    W_ACK = 1'b1; W_DAT_I = 32'hFFFF0000;
    tick();
    n_total++;
    if ({DONE, RD_DAT} !== {4'b0100, m_rd}) $display("FAIL write_done: got done=%b rd=%h, want 0100 rd=%h", DONE, RD_DAT, m_rd);
    else n_pass++;
    // acknowledge still high during FIN and IDLE must be ignored
    REQ = 4'h0; W_DAT_I = 32'hA5A5A5A5;
    tick(); tick(); tick();
    n_total++;
    if ({DONE, W_STB, GNT, RD_DAT} !== {4'h0, 1'b0, 4'h0, m_rd}) $display("FAIL ack_ignored: got done=%b stb=%b gnt=%b rd=%h, want 0 0 0 %h", DONE, W_STB, GNT, RD_DAT, m_rd);
    else n_pass++;
    W_ACK = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0]  r;
    logic [3:0]  exp_g;
    logic [31:0] exp_a, exp_d;
    logic        exp_we;
    int          w, d;
    for (int n = 0; n < 40; n++) begin
      r = 4'($urandom_range(1, 15));
      REQ = r; REQ_WE = 4'($urandom()); REQ_ADDR = rnd128(); REQ_DAT = rnd128();
      w = model_pick(r);
      exp_g = 4'b0001 << w;
      exp_a = REQ_ADDR[32*w +: 32]; exp_d = REQ_DAT[32*w +: 32]; exp_we = REQ_WE[w];
      tick();
      lw = w;
      n_total++;
      if ({W_STB, GNT, THREAD, W_ADDR, W_DAT_O, W_WRITE} !== {1'b1, exp_g, 2'(w), exp_a, exp_d, exp_we}) $display("FAIL rnd_grant%0d: got gnt=%b thr=%0d addr=%h, want gnt=%b thr=%0d addr=%h", n, GNT, THREAD, W_ADDR, exp_g, w, exp_a);
      else n_pass++;
      d = $urandom_range(0, 2);
      for (int k = 0; k < d; k++) begin
        REQ = 4'($urandom()); REQ_WE = 4'($urandom()); REQ_ADDR = rnd128(); REQ_DAT = rnd128();
        W_DAT_I = $urandom();
        tick();
        n_total++;
        if ({W_STB, GNT, W_ADDR, W_DAT_O, W_WRITE, DONE} !== {1'b1, exp_g, exp_a, exp_d, exp_we, 4'h0}) $display("FAIL rnd_hold%0d: got stb=%b gnt=%b addr=%h done=%b, want 1 %b %h 0", n, W_STB, GNT, W_ADDR, DONE, exp_g, exp_a);
        else n_pass++;
      end
      W_ACK = 1'b1; W_DAT_I = $urandom();
      if (!exp_we) m_rd = W_DAT_I;
      tick();
      n_total++;
      if ({DONE, ERR, W_STB, RD_DAT} !== {exp_g, 4'h0, 1'b0, m_rd}) $display("FAIL rnd_done%0d: got done=%b err=%b stb=%b rd=%h, want %b 0 0 %h", n, DONE, ERR, W_STB, RD_DAT, exp_g, m_rd);
      else n_pass++;
      W_ACK = 1'b0; REQ = 4'h0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    REQ = 4'b0010; REQ_WE = 4'h0;
    tick();
    n_total++;
    if (W_STB !== 1'b1) $display("FAIL rstmid_stb: got %b, want 1", W_STB);
    else n_pass++;
    W_RST = 1'b1; W_ACK = 1'b1; W_DAT_I = 32'h5555AAAA;
    tick();
    lw = 3; m_rd = 32'h0;
    n_total++;
    if ({W_STB, GNT, DONE, ERR, RD_DAT} !== {1'b0, 4'h0, 4'h0, 4'h0, m_rd}) $display("FAIL rstmid_abort: got stb=%b gnt=%b done=%b err=%b rd=%h, want all 0", W_STB, GNT, DONE, ERR, RD_DAT);
    else n_pass++;
    W_RST = 1'b0; W_ACK = 1'b0; REQ = 4'hF;
    tick();
    n_total++;
    if ({THREAD, GNT} !== {2'd0, 4'b0001}) $display("FAIL rstmid_regrant: got thr=%0d gnt=%b, want 0 0001", THREAD, GNT);
    else n_pass++;
    lw = 0;
    W_ACK = 1'b1; W_DAT_I = 32'h0BADF00D; m_rd = W_DAT_I;
    tick();
    W_ACK = 1'b0; REQ = 4'h0;
    tick();
  endtask

  task automatic test_timeout();
    REQ = 4'b1000; REQ_WE = 4'h0;
    tick();
    lw = 3;
    REQ = 4'h0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_total++;
      if ({W_STB, DONE} !== {1'b1, 4'h0}) $display("FAIL to_wait%0d: got stb=%b done=%b, want 1 0", k, W_STB, DONE);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({W_STB, DONE, ERR, RD_DAT} !== {1'b0, 4'b1000, 4'b1000, m_rd}) $display("FAIL to_expire: got stb=%b done=%b err=%b rd=%h, want 0 1000 1000 %h", W_STB, DONE, ERR, RD_DAT, m_rd);
    else n_pass++;
    tick();
    n_total++;
    if ({ERR, GNT} !== 8'h0) $display("FAIL to_fin: got err=%b gnt=%b, want 0 0", ERR, GNT);
    else n_pass++;
    REQ = 4'b0001;
    tick();
    lw = 0;
    REQ = 4'h0;
    tick(); tick(); tick();
    W_ACK = 1'b1; W_DAT_I = 32'hC0FFEE11; m_rd = W_DAT_I;
    tick();
    n_total++;
    if ({DONE, ERR, RD_DAT} !== {4'b0001, 4'h0, m_rd}) $display("FAIL to_ack_wins: got done=%b err=%b rd=%h, want 0001 0 %h", DONE, ERR, RD_DAT, m_rd);
    else n_pass++;
`else
    for (int k = 0; k < 20; k++) tick();
    n_total++;
    if ({W_STB, DONE, ERR} !== {1'b1, 4'h0, 4'h0}) $display("FAIL nto_wait: got stb=%b done=%b err=%b, want 1 0 0", W_STB, DONE, ERR);
    else n_pass++;
    W_ACK = 1'b1; W_DAT_I = 32'hC0FFEE11; m_rd = W_DAT_I;
    tick();
    n_total++;
    if ({DONE, ERR, RD_DAT} !== {4'b1000, 4'h0, m_rd}) $display("FAIL nto_done: got done=%b err=%b rd=%h, want 1000 0 %h", DONE, ERR, RD_DAT, m_rd);
    else n_pass++;
`endif
    W_ACK = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
